// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: E1 operand forwarding, load-use stall FSM, mispredict flush, memory freeze.
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rs1_e1,
    input  logic [4:0]  rs2_e1,
    input  logic [4:0]  rd_e1,
    input  logic [4:0]  rd_e2,
    input  logic [4:0]  rd_m,
    input  logic [4:0]  rd_w,
    input  logic        reg_write_e1,
    input  logic        reg_write_e2,
    input  logic        reg_write_m,
    input  logic        reg_write_w,
    input  logic [1:0]  result_src_e1,
    input  logic [1:0]  result_src_e2,
    input  logic        mispredict_e2,
    input  logic        mem_busy,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e1,
    output logic        stall_e2,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e1,
    output logic        flush_e2,
    output logic [1:0]  fwd_a_e1,
    output logic [1:0]  fwd_b_e1,
    output logic [31:0] stall_cycles,
    output logic [31:0] mispredict_count
);

    localparam int CNT_W = (LOAD_STALL_CYC > 1) ? $clog2(LOAD_STALL_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_STALL_CYC - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        RECOVER  = 2'b10
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    logic stall_f_s, stall_d_s, stall_e1_s, stall_e2_s, stall_m_s;
    logic flush_d_s, flush_e1_s, flush_e2_s;
    logic [1:0] fwd_a_s, fwd_b_s;
    logic load_e1_s, load_e2_s, misp_acc_s;

    // Youngest qualifying producer wins; a load in E2 has no result yet so it is skipped.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       e2_ok, input logic [4:0] e2_rd,
        input logic       m_ok,  input logic [4:0] m_rd,
        input logic       w_ok,  input logic [4:0] w_rd
    );
        logic [1:0] sel;
        if (e2_ok && (e2_rd != 5'd0) && (e2_rd == rs)) begin
            sel = 2'b01;
        end else if (m_ok && (m_rd != 5'd0) && (m_rd == rs)) begin
            sel = 2'b10;
        end else if (w_ok && (w_rd != 5'd0) && (w_rd == rs)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding selects and hazard detection terms
    always_comb begin
        fwd_a_s = fwd_sel(rs1_e1, reg_write_e2 && (result_src_e2 != 2'b01), rd_e2,
                          reg_write_m, rd_m, reg_write_w, rd_w);
        fwd_b_s = fwd_sel(rs2_e1, reg_write_e2 && (result_src_e2 != 2'b01), rd_e2,
                          reg_write_m, rd_m, reg_write_w, rd_w);
        load_e1_s  = (result_src_e1 == 2'b01) && (rd_e1 != 5'd0) &&
                     ((rd_e1 == rs1_d) || (rd_e1 == rs2_d));
        load_e2_s  = (result_src_e2 == 2'b01) && (rd_e2 != 5'd0) &&
                     ((rd_e2 == rs1_d) || (rd_e2 == rs2_d));
        misp_acc_s = mispredict_e2 && !mem_busy;
    end

    // Next-state and stall/flush decode
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        stall_f_s  = 1'b0;
        stall_d_s  = 1'b0;
        stall_e1_s = 1'b0;
        stall_e2_s = 1'b0;
        stall_m_s  = 1'b0;
        flush_d_s  = 1'b0;
        flush_e1_s = 1'b0;
        flush_e2_s = 1'b0;
        if (mem_busy) begin
            stall_f_s  = 1'b1;
            stall_d_s  = 1'b1;
            stall_e1_s = 1'b1;
            stall_e2_s = 1'b1;
            stall_m_s  = 1'b1;
        end else if (mispredict_e2) begin
            flush_d_s  = 1'b1;
            flush_e1_s = 1'b1;
            state_s    = RECOVER;
            cnt_s      = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (load_e1_s || load_e2_s) begin
                        stall_f_s  = 1'b1;
                        stall_d_s  = 1'b1;
                        flush_e1_s = 1'b1;
                        state_s    = LU_STALL;
                        cnt_s      = load_e1_s ? CNT_LOAD : {CNT_W{1'b0}};
                    end else begin
                        state_s = RUN;
                    end
                end
                LU_STALL: begin
                    stall_f_s  = 1'b1;
                    stall_d_s  = 1'b1;
                    flush_e1_s = 1'b1;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_s = RUN;
                    end else begin
                        cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RECOVER: begin
                    flush_d_s = 1'b1;
                    state_s   = RUN;
                end
                default: begin
                    state_s = RUN;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State and bubble counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Everything is forced quiet while reset is asserted, independent of the clock.
    assign stall_f  = rst & stall_f_s;
    assign stall_d  = rst & stall_d_s;
    assign stall_e1 = rst & stall_e1_s;
    assign stall_e2 = rst & stall_e2_s;
    assign stall_m  = rst & stall_m_s;
    assign flush_d  = rst & flush_d_s;
    assign flush_e1 = rst & flush_e1_s;
    assign flush_e2 = rst & flush_e2_s;
    assign fwd_a_e1 = rst ? fwd_a_s : 2'b00;
    assign fwd_b_e1 = rst ? fwd_b_s : 2'b00;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles_r, misp_cnt_r;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_r <= 32'd0;
            misp_cnt_r     <= 32'd0;
        end else begin
            if (stall_d_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (misp_acc_s && (misp_cnt_r != 32'hFFFF_FFFF)) begin
                misp_cnt_r <= misp_cnt_r + 32'd1;
            end else begin
                misp_cnt_r <= misp_cnt_r;
            end
        end
    end

    assign stall_cycles     = stall_cycles_r;
    assign mispredict_count = misp_cnt_r;
`else
    logic unused_perf_s;
    assign unused_perf_s    = misp_acc_s;
    assign stall_cycles     = 32'd0;
    assign mispredict_count = 32'd0;
`endif

endmodule
